// File: rtl/mvp_pll_pkg.sv
// Shared definitions for the MVP PLL lock-detect slice: state encoding and
// default widths used by the frequency lock detector and its counters.
package mvp_pll_pkg;

    localparam int MVP_CNT_W  = 16;
    localparam int MVP_TOL_W  = 8;
    localparam int MVP_LOCK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } fld_state_t;

endpackage

// File: rtl/mvp_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// once the counter reaches all-ones further increments are ignored.
module mvp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = (q == {W{1'b1}});

    // Count register: clear, else increment unless already saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mvp_freq_lock_detect.sv
// Windowed frequency comparator and lock detector. Counts synchronised
// divided-VCO event pulses over a window of reference cycles, judges each
// window against target +/- tolerance and declares lock after a run of good
// windows.
//
// Output handshake: count_valid is a one-cycle strobe with no back-pressure.
// In the cycle it is high, count_value, freq_high, freq_low, locked and
// lock_lost all describe the window that just ended; count_value and the
// freq flags hold until the next strobe, lock_lost is high only alongside a
// strobe.
module mvp_freq_lock_detect
    import mvp_pll_pkg::*;
#(
    parameter int CNT_W  = MVP_CNT_W,
    parameter int TOL_W  = MVP_TOL_W,
    parameter int LOCK_W = MVP_LOCK_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  window_len,
    input  logic [CNT_W-1:0]  target_count,
    input  logic [TOL_W-1:0]  tolerance,
    input  logic [LOCK_W-1:0] lock_count,
    output logic [CNT_W-1:0]  count_value,
    output logic              count_valid,
    output logic              freq_high,
    output logic              freq_low,
    output logic              locked,
    output logic              lock_lost,
    output logic [1:0]        state_dbg
);

    localparam int EW = CNT_W + 1;

    fld_state_t        state;
    logic [CNT_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  tgt_q;
    logic [TOL_W-1:0]  tol_q;
    logic [LOCK_W-1:0] lock_q;
    logic [LOCK_W-1:0] good_cnt;
    logic [LOCK_W-1:0] good_nxt;

    logic [CNT_W-1:0]  ev_cnt;
    logic              ev_at_max;
    logic              counting;
    logic              win_end;
    logic              ev_clr;

    logic [CNT_W-1:0]  win_len_eff;
    logic [LOCK_W-1:0] lock_cnt_eff;
    logic [CNT_W-1:0]  final_cnt;
    logic [EW-1:0]     upper;
    logic [EW-1:0]     lower;
    logic [EW-1:0]     cnt_ext;
    logic              is_high;
    logic              is_low;
    logic              is_good;

    assign state_dbg = state;

    // Event counter: cleared while idle and at every window end, so the next
    // window starts from zero with no gap cycle.
    mvp_sat_counter #(.W(CNT_W)) u_ev_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (ev_clr),
        .inc     (pulse_in),
        .q       (ev_cnt),
        .at_max  (ev_at_max)
    );

    // Window bookkeeping and the window judgement in CNT_W+1 bits so the
    // upper bound cannot overflow and the lower bound clamps at zero.
    always_comb begin
        counting     = (state != ST_IDLE) && enable;
        win_end      = counting && (win_cnt == CNT_W'(1));
        ev_clr       = !counting || win_end;
        win_len_eff  = (window_len == '0) ? CNT_W'(1) : window_len;
        lock_cnt_eff = (lock_count == '0) ? LOCK_W'(1) : lock_count;
        final_cnt    = ev_at_max ? ev_cnt : ev_cnt + CNT_W'(pulse_in);
        cnt_ext      = {1'b0, final_cnt};
        upper        = {1'b0, tgt_q} + EW'(tol_q);
        lower        = ({1'b0, tgt_q} >= EW'(tol_q)) ? ({1'b0, tgt_q} - EW'(tol_q)) : '0;
        is_high      = cnt_ext > upper;
        is_low       = cnt_ext < lower;
        is_good      = !is_high && !is_low;
        good_nxt     = good_cnt + LOCK_W'(1);
    end

    // Lock FSM, window counter, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            win_cnt     <= '0;
            tgt_q       <= '0;
            tol_q       <= '0;
            lock_q      <= '0;
            good_cnt    <= '0;
            count_value <= '0;
            count_valid <= 1'b0;
            freq_high   <= 1'b0;
            freq_low    <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            lock_lost   <= 1'b0;
            if (!enable) begin
                // Partial window is dropped; measurement outputs keep history.
                state    <= ST_IDLE;
                win_cnt  <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ACQ;
                        win_cnt  <= win_len_eff;
                        tgt_q    <= target_count;
                        tol_q    <= tolerance;
                        lock_q   <= lock_cnt_eff;
                        good_cnt <= '0;
                    end
                    ST_ACQ, ST_LOCK: begin
                        if (win_end) begin
                            win_cnt     <= win_len_eff;
                            tgt_q       <= target_count;
                            tol_q       <= tolerance;
                            lock_q      <= lock_cnt_eff;
                            count_value <= final_cnt;
                            count_valid <= 1'b1;
                            freq_high   <= is_high;
                            freq_low    <= is_low;
                            if (state == ST_ACQ) begin
                                if (!is_good) begin
                                    good_cnt <= '0;
                                end else if (good_nxt >= lock_q) begin
                                    state    <= ST_LOCK;
                                    locked   <= 1'b1;
                                    good_cnt <= '0;
                                end else begin
                                    good_cnt <= good_nxt;
                                end
                            end else if (!is_good) begin
                                state     <= ST_ACQ;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                                good_cnt  <= '0;
                            end
                        end else begin
                            win_cnt <= win_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        win_cnt  <= '0;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mvp_freq_lock_detect.sv
// Bench for mvp_freq_lock_detect: directed windows with hand-computed
// results queued as expected strobes, a monitor matching every count_valid,
// plus direct checks around reset and enable drops.
module tb_mvp_freq_lock_detect;
    import mvp_pll_pkg::*;

    localparam int CNT_W  = 16;
    localparam int TOL_W  = 8;
    localparam int LOCK_W = 4;
    localparam int EXP_W  = CNT_W + 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              enable = 1'b0;
    logic              pulse_in = 1'b0;
    logic [CNT_W-1:0]  window_len = '0;
    logic [CNT_W-1:0]  target_count = '0;
    logic [TOL_W-1:0]  tolerance = '0;
    logic [LOCK_W-1:0] lock_count = '0;
    logic [CNT_W-1:0]  count_value;
    logic              count_valid;
    logic              freq_high;
    logic              freq_low;
    logic              locked;
    logic              lock_lost;
    logic [1:0]        state_dbg;

    mvp_freq_lock_detect #(.CNT_W(CNT_W), .TOL_W(TOL_W), .LOCK_W(LOCK_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .window_len   (window_len),
        .target_count (target_count),
        .tolerance    (tolerance),
        .lock_count   (lock_count),
        .count_value  (count_value),
        .count_valid  (count_valid),
        .freq_high    (freq_high),
        .freq_low     (freq_low),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .state_dbg    (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void push_exp(input int cnt, input bit hi, input bit lo, input bit lk, input bit ll);
        exp_q.push_back({CNT_W'(cnt), hi, lo, lk, ll});
    endfunction

    // scoreboard monitor: every strobe must match the oldest expected window
    initial begin
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (count_valid === 1'b1) begin
                act = {count_value, freq_high, freq_low, locked, lock_lost};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: got count=%0d hi=%0d lo=%0d lk=%0d ll=%0d expected no strobe",
                             count_value, freq_high, freq_low, locked, lock_lost);
                end else begin
                    exp = exp_q.pop_front();
                    if (act === exp) n_pass++;
                    else $display("FAIL window: got count=%0d hi=%0d lo=%0d lk=%0d ll=%0d expected count=%0d hi=%0d lo=%0d lk=%0d ll=%0d",
                                  act[EXP_W-1:4], act[3], act[2], act[1], act[0],
                                  exp[EXP_W-1:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic set_cfg(input int w, input int t, input int tol, input int lk);
        @(negedge clk);
        window_len   = CNT_W'(w);
        target_count = CNT_W'(t);
        tolerance    = TOL_W'(tol);
        lock_count   = LOCK_W'(lk);
    endtask

    task automatic start_enable();
        @(negedge clk);
        enable   = 1'b1;
        pulse_in = 1'b0;
    endtask

    task automatic stop_enable();
        @(negedge clk);
        enable   = 1'b0;
        pulse_in = 1'b0;
    endtask

    // alt=1: pulse on every second cycle; else first k cycles of each window
    task automatic run_cycles(input int ncyc, input int w, input int k, input bit alt);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (alt) pulse_in = (i % 2 == 1);
            else     pulse_in = ((i % w) < k);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // reset state
        idle_cycles(3);
        @(posedge clk); #1;
        check("rst_count_value", 32'(count_value), 0);
        check("rst_count_valid", 32'(count_valid), 0);
        check("rst_freq_high", 32'(freq_high), 0);
        check("rst_freq_low", 32'(freq_low), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_lock_lost", 32'(lock_lost), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;

        // 50 per window against 50+/-2, lock after three good windows
        set_cfg(100, 50, 2, 3);
        push_exp(50, 0, 0, 0, 0);
        push_exp(50, 0, 0, 0, 0);
        push_exp(50, 0, 0, 1, 0);
        push_exp(50, 0, 0, 1, 0);
        start_enable();
        run_cycles(400, 100, 0, 1'b1);

        // too fast while locked, then relock
        push_exp(55, 1, 0, 0, 1);
        push_exp(50, 0, 0, 0, 0);
        push_exp(50, 0, 0, 0, 0);
        push_exp(50, 0, 0, 1, 0);
        run_cycles(100, 100, 55, 1'b0);
        run_cycles(300, 100, 0, 1'b1);
        stop_enable();

        // zero events, lower bound clamps at zero; lock_count 0 acts as 1
        set_cfg(10, 1, 5, 0);
        push_exp(0, 0, 0, 1, 0);
        push_exp(0, 0, 0, 1, 0);
        start_enable();
        run_cycles(20, 10, 0, 1'b0);
        stop_enable();

        // too slow in acquisition: no lock_lost, then lock after two good
        set_cfg(30, 20, 2, 2);
        push_exp(10, 0, 1, 0, 0);
        push_exp(20, 0, 0, 0, 0);
        push_exp(20, 0, 0, 1, 0);
        start_enable();
        run_cycles(30, 30, 10, 1'b0);
        run_cycles(60, 30, 20, 1'b0);
        stop_enable();

        // window_len 0 acts as 1: a strobe every cycle with 0/1 counts
        set_cfg(0, 1, 0, 2);
        push_exp(0, 0, 1, 0, 0);
        push_exp(1, 0, 0, 0, 0);
        push_exp(0, 0, 1, 0, 0);
        push_exp(1, 0, 0, 0, 0);
        start_enable();
        run_cycles(4, 1, 0, 1'b1);
        stop_enable();

        // full-scale window with pulse held high; upper bound beyond CNT_W
        set_cfg(65535, 65535, 255, 1);
        push_exp(65535, 0, 0, 1, 0);
        start_enable();
        run_cycles(65535, 65535, 65535, 1'b0);
        stop_enable();

        // enable dropped mid-window while locked
        set_cfg(20, 10, 1, 1);
        push_exp(10, 0, 0, 1, 0);
        start_enable();
        run_cycles(20, 20, 10, 1'b0);
        run_cycles(7, 20, 10, 1'b0);
        stop_enable();
        @(posedge clk); #1;
        check("drop_locked", 32'(locked), 0);
        check("drop_lock_lost", 32'(lock_lost), 0);
        check("drop_state", 32'(state_dbg), 32'(ST_IDLE));
        check("drop_count_hold", 32'(count_value), 10);
        idle_cycles(3);

        // re-enable: a full fresh window, partial pulses discarded
        set_cfg(20, 5, 0, 1);
        push_exp(5, 0, 0, 1, 0);
        start_enable();
        run_cycles(20, 20, 5, 1'b0);
        // drop enable on the window-end cycle: that window is discarded
        run_cycles(19, 20, 5, 1'b0);
        stop_enable();
        @(posedge clk); #1;
        check("end_drop_locked", 32'(locked), 0);
        check("end_drop_count_hold", 32'(count_value), 5);
        idle_cycles(5);

        // async reset mid-window while locked
        set_cfg(20, 10, 1, 1);
        push_exp(11, 0, 0, 1, 0);
        start_enable();
        run_cycles(20, 20, 11, 1'b0);
        run_cycles(5, 20, 11, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count_value", 32'(count_value), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        enable   = 1'b0;
        pulse_in = 1'b0;
        idle_cycles(2);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("post_rst_locked", 32'(locked), 0);

        // resumes normally after reset
        push_exp(10, 0, 0, 1, 0);
        start_enable();
        run_cycles(20, 20, 10, 1'b0);
        stop_enable();
        idle_cycles(5);

        check("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
